// File: rtl/traffic_rr_jam_ctrl_pkg.sv
// Shared types and index helpers for the rotating-priority traffic controller.
// Package is named traffic_pkg; all controller files import it.
package traffic_pkg;

  typedef enum logic {
    PH_CLEAR = 1'b0,
    PH_GREEN = 1'b1
  } phase_t;

  localparam int DEFAULT_N_WAYS = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEFAULT_IDX_W = idx_w(DEFAULT_N_WAYS);

  // Cyclic increment; n need not be a power of two.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/traffic_rr_jam_ctrl_if.sv
// Jam-sensor / light-control bundle between the controller and its environment.
interface traffic_rr_jam_ctrl_if
  import traffic_pkg::*;
#(
  parameter int N_WAYS = DEFAULT_N_WAYS
);
  localparam int IW = idx_w(N_WAYS);

  logic [N_WAYS-1:0] jam_sensor;
  logic [N_WAYS-1:0] allow;
  logic [IW-1:0]     green_idx;
  logic              phase_green;

  modport master (
    output jam_sensor,
    input  allow,
    input  green_idx,
    input  phase_green
  );

  modport slave (
    input  jam_sensor,
    output allow,
    output green_idx,
    output phase_green
  );
endinterface

// File: rtl/traffic_rr_jam_ctrl_pick.sv
// Combinational rotating-priority picker: jammed candidates win, otherwise any
// candidate, searching cyclically from start_i.
module traffic_rr_pick
  import traffic_pkg::*;
#(
  parameter  int N_WAYS = 4,
  localparam int IW     = idx_w(N_WAYS)
) (
  input  logic [N_WAYS-1:0] cand_i,
  input  logic [N_WAYS-1:0] jam_i,
  input  logic [IW-1:0]     start_i,
  output logic [IW-1:0]     pick_o,
  output logic              valid_o
);

  logic [N_WAYS-1:0] jam_cand;
  logic [N_WAYS-1:0] pool;

  assign jam_cand = cand_i & jam_i;
  assign pool     = (|jam_cand) ? jam_cand : cand_i;
  assign valid_o  = |cand_i;

  always_comb begin
    logic [IW-1:0] idx;
    logic          found;
    pick_o = '0;
    idx    = start_i;
    found  = 1'b0;
    for (int k = 0; k < N_WAYS; k++) begin
      if (!found && pool[idx]) begin
        found  = 1'b1;
        pick_o = idx;
      end
      idx = IW'(next_idx(int'(idx), N_WAYS));
    end
  end

endmodule

// File: rtl/traffic_rr_jam_ctrl.sv
// N-way traffic light controller: one green at a time, all-red gap between greens,
// jam-first round-robin service with a served mask so every approach gets a turn.
module traffic_rr_jam_ctrl
  import traffic_pkg::*;
#(
  parameter int N_WAYS       = 4,
  parameter int GREEN_CYCLES = 10,
  parameter int MAX_GREEN    = 20,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  traffic_rr_jam_ctrl_if.slave  bus
);

  localparam int IW = idx_w(N_WAYS);
  // Timer must hold both the green cap and the clearance length.
  localparam int TMAX = (MAX_GREEN > CLEAR_CYCLES) ? MAX_GREEN : CLEAR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  if (N_WAYS < 2) begin : g_bad_n_ways
    $error("traffic_rr_jam_ctrl: N_WAYS must be >= 2");
  end
  if (GREEN_CYCLES < 1) begin : g_bad_green
    $error("traffic_rr_jam_ctrl: GREEN_CYCLES must be >= 1");
  end
  if (MAX_GREEN < GREEN_CYCLES) begin : g_bad_max
    $error("traffic_rr_jam_ctrl: MAX_GREEN must be >= GREEN_CYCLES");
  end
  if (CLEAR_CYCLES < 1) begin : g_bad_clear
    $error("traffic_rr_jam_ctrl: CLEAR_CYCLES must be >= 1");
  end

  phase_t            state_q;
  logic [TW-1:0]     timer_q;
  logic [N_WAYS-1:0] served_q;
  logic [N_WAYS-1:0] allow_q;
  logic [IW-1:0]     green_idx_q;
  logic              phase_green_q;

  logic [N_WAYS-1:0] cur_oh;
  logic              round_done;
  logic [N_WAYS-1:0] cand_d;
  logic [IW-1:0]     start_idx;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic [N_WAYS-1:0] pick_oh;
  logic [N_WAYS-1:0] served_d;
  logic              jam_cur;
  logic              clear_end;
  logic              green_end;

  assign cur_oh     = N_WAYS'(1) << green_idx_q;
  assign round_done = &served_q;
  // At a round boundary the approach just served is barred from an immediate repeat.
  assign cand_d     = round_done ? ~cur_oh : ~served_q;
  assign start_idx  = IW'(next_idx(int'(green_idx_q), N_WAYS));
  assign pick_oh    = N_WAYS'(1) << pick_idx;
  assign served_d   = (round_done ? '0 : served_q) | pick_oh;

  assign jam_cur    = bus.jam_sensor[green_idx_q];
  assign clear_end  = (timer_q == TW'(CLEAR_CYCLES - 1));
  // Past the minimum, green persists only while its own jam flag stays high.
  assign green_end  = (timer_q == TW'(MAX_GREEN - 1)) ||
                      ((timer_q >= TW'(GREEN_CYCLES - 1)) && !jam_cur);

  traffic_rr_pick #(
    .N_WAYS (N_WAYS)
  ) u_pick (
    .cand_i  (cand_d),
    .jam_i   (bus.jam_sensor),
    .start_i (start_idx),
    .pick_o  (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= PH_CLEAR;
      timer_q       <= '0;
      served_q      <= '0;
      allow_q       <= '0;
      green_idx_q   <= IW'(N_WAYS - 1);
      phase_green_q <= 1'b0;
    end else begin
      case (state_q)
        PH_CLEAR: begin
          if (clear_end && pick_valid) begin
            state_q       <= PH_GREEN;
            timer_q       <= '0;
            green_idx_q   <= pick_idx;
            allow_q       <= pick_oh;
            phase_green_q <= 1'b1;
            served_q      <= served_d;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        PH_GREEN: begin
          if (green_end) begin
            state_q       <= PH_CLEAR;
            timer_q       <= '0;
            allow_q       <= '0;
            phase_green_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q       <= PH_CLEAR;
          timer_q       <= '0;
          allow_q       <= '0;
          phase_green_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.allow       = allow_q;
  assign bus.green_idx   = green_idx_q;
  assign bus.phase_green = phase_green_q;

endmodule

// File: tb/tb_traffic_rr_jam_ctrl.sv
// Directed bench for traffic_rr_jam_ctrl: a default 4-way instance and a fast 3-way
// instance, each grant measured for index, green length and all-red gap.
module tb_traffic_rr_jam_ctrl;
  import traffic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a;
  logic rst_n_b;

  traffic_rr_jam_ctrl_if #(.N_WAYS(4)) ifa ();
  traffic_rr_jam_ctrl_if #(.N_WAYS(3)) ifb ();

  traffic_rr_jam_ctrl dut_a (
    .clk   (clk),
    .rst_n (rst_n_a),
    .bus   (ifa)
  );

  traffic_rr_jam_ctrl #(
    .N_WAYS       (3),
    .GREEN_CYCLES (1),
    .MAX_GREEN    (3),
    .CLEAR_CYCLES (1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n_b),
    .bus   (ifb)
  );

  int errs   = 0;
  int checks = 0;
  int gap_seen;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic logic [3:0] get_allow(input bit sel);
    return sel ? {1'b0, ifb.allow} : ifa.allow;
  endfunction

  function automatic int get_idx(input bit sel);
    return sel ? int'(ifb.green_idx) : int'(ifa.green_idx);
  endfunction

  function automatic logic get_phase(input bit sel);
    return sel ? ifb.phase_green : ifa.phase_green;
  endfunction

  function automatic logic [3:0] get_jam(input bit sel);
    return sel ? {1'b0, ifb.jam_sensor} : ifa.jam_sensor;
  endfunction

  task automatic set_jam(input bit sel, input logic [3:0] v);
    if (sel) ifb.jam_sensor = v[2:0];
    else     ifa.jam_sensor = v;
  endtask

  function automatic int oh2idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Measures one grant: gap before it, its index and its green length.
  task automatic grant(input bit sel, input string tag, input int exp_idx,
                       input int exp_len, input int exp_gap,
                       input int pulse_way = -1, input int pulse_lo = 0,
                       input int pulse_hi = 0);
    int gap, len, idx, n, bad_oh, bad_ph, bad_gi;
    logic [3:0] a;
    logic [3:0] j;
    gap = gap_seen; n = 0; len = 0;
    bad_oh = 0; bad_ph = 0; bad_gi = 0;
    a = '0;
    while (n < 200) begin
      @(negedge clk);
      a = get_allow(sel);
      if (a != 4'd0) break;
      gap++; n++;
    end
    idx = oh2idx(a);
    while (a != 4'd0 && len < 200) begin
      len++;
      if ($countones(a) != 1) bad_oh++;
      if (get_phase(sel) !== 1'b1) bad_ph++;
      if (get_idx(sel) != idx) bad_gi++;
      if (pulse_way >= 0) begin
        j = get_jam(sel);
        j[pulse_way] = (len >= pulse_lo) && (len <= pulse_hi);
        set_jam(sel, j);
      end
      @(negedge clk);
      a = get_allow(sel);
    end
    if (pulse_way >= 0) begin
      j = get_jam(sel);
      j[pulse_way] = 1'b0;
      set_jam(sel, j);
    end
    if (get_phase(sel) !== 1'b0) bad_ph++;
    gap_seen = 1;
    check_val({tag, ".idx"}, idx, exp_idx);
    check_val({tag, ".len"}, len, exp_len);
    check_val({tag, ".gap"}, gap, exp_gap);
    check_val({tag, ".multihot"}, bad_oh, 0);
    check_val({tag, ".phase"}, bad_ph, 0);
    check_val({tag, ".green_idx"}, bad_gi, 0);
  endtask

  task automatic release_a();
    @(negedge clk);
    rst_n_a  = 1'b1;
    gap_seen = 1;
  endtask

  initial begin
    int n;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    ifa.jam_sensor = '0;
    ifb.jam_sensor = '0;

    // Reset state of the 4-way instance
    repeat (2) @(negedge clk);
    check_val("rst.allow", int'(ifa.allow), 0);
    check_val("rst.phase", int'(ifa.phase_green), 0);
    check_val("rst.green_idx", int'(ifa.green_idx), 3);
    rst_n_a  = 1'b1;
    gap_seen = 1;

    // Plain round robin, 12-cycle slots
    grant(0, "rr0", 0, 10, 2);
    grant(0, "rr1", 1, 10, 2);
    grant(0, "rr2", 2, 10, 2);
    grant(0, "rr3", 3, 10, 2);
    grant(0, "rr4", 0, 10, 2);
    grant(0, "rr5", 1, 10, 2);

    // Asynchronous reset in the middle of approach 2's green
    n = 0;
    while (ifa.allow != 4'b0100 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check_val("arst.pre_allow", int'(ifa.allow), 4);
    #1 rst_n_a = 1'b0;
    #1;
    check_val("arst.allow", int'(ifa.allow), 0);
    check_val("arst.phase", int'(ifa.phase_green), 0);
    check_val("arst.green_idx", int'(ifa.green_idx), 3);
    repeat (2) @(negedge clk);
    rst_n_a  = 1'b1;
    gap_seen = 1;
    grant(0, "arst.first", 0, 10, 2);

    // Approach 2 jammed throughout
    rst_n_a = 1'b0;
    ifa.jam_sensor = 4'b0100;
    @(negedge clk);
    release_a();
    grant(0, "jam0", 2, 20, 2);
    grant(0, "jam1", 3, 10, 2);
    grant(0, "jam2", 0, 10, 2);
    grant(0, "jam3", 1, 10, 2);
    grant(0, "jam4", 2, 20, 2);
    grant(0, "jam5", 3, 10, 2);

    // Jam on approach 1 during green cycles 3..14 ends green after 15
    rst_n_a = 1'b0;
    ifa.jam_sensor = 4'b0000;
    @(negedge clk);
    release_a();
    grant(0, "pulse0", 0, 10, 2);
    grant(0, "pulse1", 1, 15, 2, 1, 3, 14);
    grant(0, "pulse2", 2, 10, 2);
    grant(0, "pulse3", 3, 10, 2);

    // Round boundary: jam on the just-served approach 3 must not re-grant it
    ifa.jam_sensor = 4'b1000;
    grant(0, "bound0", 0, 10, 2);
    grant(0, "bound1", 3, 20, 2);
    ifa.jam_sensor = 4'b0000;
    rst_n_a = 1'b0;

    // Fast 3-way instance, no jams
    check_val("b.rst.allow", int'(ifb.allow), 0);
    check_val("b.rst.green_idx", int'(ifb.green_idx), 2);
    @(negedge clk);
    rst_n_b  = 1'b1;
    gap_seen = 1;
    grant(1, "b0", 0, 1, 1);
    grant(1, "b1", 1, 1, 1);
    grant(1, "b2", 2, 1, 1);
    grant(1, "b3", 0, 1, 1);

    // Fast 3-way instance, all jammed: every green hits the 3-cycle cap
    rst_n_b = 1'b0;
    ifb.jam_sensor = 3'b111;
    @(negedge clk);
    rst_n_b  = 1'b1;
    gap_seen = 1;
    grant(1, "bj0", 0, 3, 1);
    grant(1, "bj1", 1, 3, 1);
    grant(1, "bj2", 2, 3, 1);
    grant(1, "bj3", 0, 3, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
